core_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the 32-bit core datapath: fetch, decode, execute, memory access and writeback.
- Drives every datapath control strobe and the memory read/write strobes.
- Decodes the instruction register into the immediate value and register addresses.
- Waits on the memory ready handshake, bounded by a timeout counter.

---
 rtl/core_pkg.sv | 86 ++++++++
 rtl/core_imm_gen.sv | 29 ++
 rtl/core_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_core_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types, encodings and decode helpers for the multi-cycle core controller.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned TMO_W  = 8;

  typedef logic [3:0] state_t;

  localparam state_t S_RESET      = 4'd0;
  localparam state_t S_FETCH      = 4'd1;
  localparam state_t S_DECODE     = 4'd2;
  localparam state_t S_EXEC       = 4'd3;
  localparam state_t S_WB         = 4'd4;
  localparam state_t S_ADDR       = 4'd5;
  localparam state_t S_MEM_RD     = 4'd6;
  localparam state_t S_MEM_WR     = 4'd7;
  localparam state_t S_BRANCH_CMP = 4'd8;
  localparam state_t S_BRANCH_TGT = 4'd9;
  localparam state_t S_JAL_LINK   = 4'd10;
  localparam state_t S_HALT       = 4'd11;
  localparam state_t S_FAULT      = 4'd12;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_0073;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } alu_dec_t;

  // Map funct3/funct7 onto the 8-op ALU; SLTIU/SLTU and SRA forms are not supported.
  function automatic alu_dec_t decode_alu(input logic [2:0] funct3,
                                          input logic [6:0] funct7,
                                          input logic       is_imm);
    alu_dec_t d;
    d.legal = 1'b1;
    d.op    = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (is_imm || funct7 == 7'h00) d.op = ALU_ADD;
        else if (funct7 == 7'h20)      d.op = ALU_SUB;
        else                           d.legal = 1'b0;
      end
      3'b001: begin d.op = ALU_SLL; d.legal = (funct7 == 7'h00); end
      3'b010: begin d.op = ALU_SLT; d.legal = is_imm || (funct7 == 7'h00); end
      3'b100: begin d.op = ALU_XOR; d.legal = is_imm || (funct7 == 7'h00); end
      3'b101: begin d.op = ALU_SRL; d.legal = (funct7 == 7'h00); end
      3'b110: begin d.op = ALU_OR;  d.legal = is_imm || (funct7 == 7'h00); end
      3'b111: begin d.op = ALU_AND; d.legal = is_imm || (funct7 == 7'h00); end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/core_imm_gen.sv
// Combinational immediate extractor: selects the RV32I format from the opcode and sign-extends.
module core_imm_gen
  import core_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_t        fmt_o
);

  always_comb begin
    fmt_o = IMM_NONE;
    imm_o = '0;
    case (ir_i[6:0])
      OPC_OP_IMM, OPC_LOAD: fmt_o = IMM_I;
      OPC_STORE:            fmt_o = IMM_S;
      OPC_BRANCH:           fmt_o = IMM_B;
      OPC_JAL:              fmt_o = IMM_J;
      default:              fmt_o = IMM_NONE;
    endcase
    case (fmt_o)
      IMM_I: imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
      IMM_S: imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      IMM_B: imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      IMM_J: imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle control FSM for the 32-bit core: fetch, decode, execute, memory and writeback.
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PC_STEP     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   ir_i,
  input  logic [2:0]        alu_flag_i,
  input  logic              mem_ready_i,
  output logic              en_rf_o,
  output logic              we_rf_o,
  output logic              sel_rf_o,
  output logic              en_pc_o,
  output logic              rstn_pc_o,
  output logic              load_pc_o,
  output logic              we_ir_o,
  output logic              load_addr_reg_o,
  output logic              sel_alu_port_a_o,
  output logic              sel_alu_port_b_o,
  output logic [2:0]        alu_op_o,
  output logic              we_mem_o,
  output logic              re_mem_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] rf_addr_a_o,
  output logic [REG_AW-1:0] rf_addr_b_o,
  output logic              halt_o,
  output logic              fault_o
);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              halt_q, halt_d;
  logic              fault_q, fault_d;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              is_op_imm, is_load;
  logic              br_legal, br_taken, timed_out;
  logic [XLEN-1:0]   imm_raw, imm_adj;
  imm_fmt_t          imm_fmt;
  alu_dec_t          alu_dec;
  logic              unused_carry;

  assign opcode    = ir_i[6:0];
  assign rd        = ir_i[11:7];
  assign funct3    = ir_i[14:12];
  assign rs1       = ir_i[19:15];
  assign rs2       = ir_i[24:20];
  assign funct7    = ir_i[31:25];
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign alu_dec   = decode_alu(funct3, funct7, is_op_imm);
  assign timed_out = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign unused_carry = alu_flag_i[FLAG_CARRY];

  core_imm_gen u_imm_gen (
    .ir_i  (ir_i),
    .imm_o (imm_raw),
    .fmt_o (imm_fmt)
  );

  // PC has already advanced in FETCH, so PC-relative offsets are pulled back by one step.
  assign imm_adj = (imm_fmt == IMM_B || imm_fmt == IMM_J) ? imm_raw - XLEN'(PC_STEP) : imm_raw;

  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken =  alu_flag_i[FLAG_ZERO];
      3'b001:  br_taken = ~alu_flag_i[FLAG_ZERO];
      3'b100:  br_taken =  alu_flag_i[FLAG_NEG];
      3'b101:  br_taken = ~alu_flag_i[FLAG_NEG];
      default: br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
      tmo_q   <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  end

  assign halt_o  = halt_q;
  assign fault_o = fault_q;

  // Next state plus Moore-decoded strobes; the wait counter resets whenever a memory state is left.
  always_comb begin
    state_d          = state_q;
    tmo_d            = '0;
    halt_d           = halt_q;
    fault_d          = fault_q;
    en_rf_o          = 1'b0;
    we_rf_o          = 1'b0;
    sel_rf_o         = 1'b0;
    en_pc_o          = 1'b0;
    rstn_pc_o        = 1'b1;
    load_pc_o        = 1'b0;
    we_ir_o          = 1'b0;
    load_addr_reg_o  = 1'b0;
    sel_alu_port_a_o = 1'b0;
    sel_alu_port_b_o = 1'b0;
    alu_op_o         = ALU_ADD;
    we_mem_o         = 1'b0;
    re_mem_o         = 1'b0;
    imm_o            = imm_adj;
    rf_addr_a_o      = rs1;
    rf_addr_b_o      = rs2;

    case (state_q)
      S_RESET: begin
        rstn_pc_o   = 1'b0;
        imm_o       = '0;
        rf_addr_a_o = '0;
        rf_addr_b_o = '0;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        re_mem_o = 1'b1;
        we_ir_o  = 1'b1;
        if (mem_ready_i) begin
          en_pc_o = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        en_rf_o = 1'b1;
        case (opcode)
          OPC_OP, OPC_OP_IMM:  state_d = alu_dec.legal ? S_EXEC : S_FAULT;
          OPC_LOAD, OPC_STORE: state_d = (funct3 == 3'b010) ? S_ADDR : S_FAULT;
          OPC_BRANCH:          state_d = br_legal ? S_BRANCH_CMP : S_FAULT;
          OPC_JAL:             state_d = S_JAL_LINK;
          OPC_SYSTEM:          state_d = (ir_i == HALT_INSTR) ? S_HALT : S_FAULT;
          default:             state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        en_rf_o          = 1'b1;
        sel_alu_port_b_o = is_op_imm;
        alu_op_o         = alu_dec.op;
        state_d          = S_WB;
      end
      S_WB: begin
        en_rf_o     = 1'b1;
        we_rf_o     = (rd != 5'd0);
        rf_addr_a_o = rd;
        sel_rf_o    = is_load;
        if (!is_load) begin
          sel_alu_port_b_o = is_op_imm;
          alu_op_o         = alu_dec.op;
        end
        state_d = S_FETCH;
      end
      S_ADDR: begin
        en_rf_o          = 1'b1;
        sel_alu_port_b_o = 1'b1;
        load_addr_reg_o  = 1'b1;
        state_d          = is_load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        re_mem_o = 1'b1;
        if (mem_ready_i)    state_d = S_WB;
        else if (timed_out) state_d = S_FAULT;
        else                tmo_d   = tmo_q + TMO_W'(1);
      end
      S_MEM_WR: begin
        en_rf_o  = 1'b1;
        we_mem_o = 1'b1;
        if (mem_ready_i)    state_d = S_FETCH;
        else if (timed_out) state_d = S_FAULT;
        else                tmo_d   = tmo_q + TMO_W'(1);
      end
      S_BRANCH_CMP: begin
        en_rf_o  = 1'b1;
        alu_op_o = ALU_SUB;
        state_d  = br_taken ? S_BRANCH_TGT : S_FETCH;
      end
      S_BRANCH_TGT: begin
        sel_alu_port_a_o = 1'b1;
        sel_alu_port_b_o = 1'b1;
        load_pc_o        = 1'b1;
        state_d          = S_FETCH;
      end
      S_JAL_LINK: begin
        // Link value is pc + x0, reusing port B as the constant zero source.
        en_rf_o          = 1'b1;
        sel_alu_port_a_o = 1'b1;
        rf_addr_a_o      = rd;
        rf_addr_b_o      = '0;
        we_rf_o          = (rd != 5'd0);
        state_d          = S_BRANCH_TGT;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    if (state_d == S_HALT)  halt_d  = 1'b1;
    if (state_d == S_FAULT) fault_d = 1'b1;
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: walks instruction classes, memory waits, timeout, fault and halt.
module tb_core_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ir_i;
  logic [2:0]  alu_flag_i;
  logic        mem_ready_i;
  logic        en_rf_o, we_rf_o, sel_rf_o, en_pc_o, rstn_pc_o, load_pc_o, we_ir_o;
  logic        load_addr_reg_o, sel_alu_port_a_o, sel_alu_port_b_o, we_mem_o, re_mem_o;
  logic [2:0]  alu_op_o;
  logic [31:0] imm_o;
  logic [4:0]  rf_addr_a_o, rf_addr_b_o;
  logic        halt_o, fault_o;

  int checks = 0;
  int errors = 0;
  logic [11:0] strb;

  core_ctrl #(.MEM_TIMEOUT(16), .PC_STEP(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ir_i             (ir_i),
    .alu_flag_i       (alu_flag_i),
    .mem_ready_i      (mem_ready_i),
    .en_rf_o          (en_rf_o),
    .we_rf_o          (we_rf_o),
    .sel_rf_o         (sel_rf_o),
    .en_pc_o          (en_pc_o),
    .rstn_pc_o        (rstn_pc_o),
    .load_pc_o        (load_pc_o),
    .we_ir_o          (we_ir_o),
    .load_addr_reg_o  (load_addr_reg_o),
    .sel_alu_port_a_o (sel_alu_port_a_o),
    .sel_alu_port_b_o (sel_alu_port_b_o),
    .alu_op_o         (alu_op_o),
    .we_mem_o         (we_mem_o),
    .re_mem_o         (re_mem_o),
    .imm_o            (imm_o),
    .rf_addr_a_o      (rf_addr_a_o),
    .rf_addr_b_o      (rf_addr_b_o),
    .halt_o           (halt_o),
    .fault_o          (fault_o)
  );

  always #5 clk_i = ~clk_i;

  // {en_rf, we_rf, sel_rf, en_pc, rstn_pc, load_pc, we_ir, load_addr, sel_a, sel_b, we_mem, re_mem}
  assign strb = {en_rf_o, we_rf_o, sel_rf_o, en_pc_o, rstn_pc_o, load_pc_o, we_ir_o,
                 load_addr_reg_o, sel_alu_port_a_o, sel_alu_port_b_o, we_mem_o, re_mem_o};

  localparam logic [11:0] P_RESET   = 12'h000;
  localparam logic [11:0] P_FETCH   = 12'h1A1;
  localparam logic [11:0] P_FETCH_W = 12'h0A1;
  localparam logic [11:0] P_DECODE  = 12'h880;
  localparam logic [11:0] P_EXEC_I  = 12'h884;
  localparam logic [11:0] P_EXEC_R  = 12'h880;
  localparam logic [11:0] P_WB_I    = 12'hC84;
  localparam logic [11:0] P_WB_R    = 12'hC80;
  localparam logic [11:0] P_WB_X0   = 12'h880;
  localparam logic [11:0] P_WB_LD   = 12'hE80;
  localparam logic [11:0] P_ADDR    = 12'h894;
  localparam logic [11:0] P_MEM_RD  = 12'h081;
  localparam logic [11:0] P_BCMP    = 12'h880;
  localparam logic [11:0] P_BTGT    = 12'h0CC;
  localparam logic [11:0] P_JLINK   = 12'hC88;
  localparam logic [11:0] P_IDLE    = 12'h080;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0080_A103;
  localparam logic [31:0] I_BEQ   = 32'hFE20_8CE3;
  localparam logic [31:0] I_BNE   = 32'hFE20_9CE3;
  localparam logic [31:0] I_ADDX0 = 32'h0020_8033;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_JAL   = 32'h0100_00EF;
  localparam logic [31:0] I_ILL   = 32'h0000_007F;
  localparam logic [31:0] I_HALT  = 32'h0000_0073;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look(input string tag, input logic [11:0] exp_strb, input logic [2:0] exp_alu);
    #1;
    chk({tag, ".strb"}, 32'(strb), 32'(exp_strb));
    chk({tag, ".alu"}, 32'(alu_op_o), 32'(exp_alu));
  endtask

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b1; ir_i = 32'h0; alu_flag_i = 3'b000;
    tick(); tick();
    look("reset", P_RESET, 3'd0);
    chk("reset.imm", imm_o, 32'h0);
    chk("reset.rfa", 32'(rf_addr_a_o), 32'h0);
    chk("reset.flags", 32'({halt_o, fault_o}), 32'h0);
    rst_i = 1'b0;
    look("reset_rel", P_RESET, 3'd0);
    tick();

    // ADDI x1, x0, 5
    ir_i = I_ADDI;
    look("addi_fetch", P_FETCH, 3'd0);
    tick(); look("addi_dec", P_DECODE, 3'd0);
    chk("addi_dec.imm", imm_o, 32'd5);
    tick(); look("addi_exec", P_EXEC_I, 3'd0);
    tick(); look("addi_wb", P_WB_I, 3'd0);
    chk("addi_wb.rfa", 32'(rf_addr_a_o), 32'd1);
    chk("addi_wb.imm", imm_o, 32'd5);
    tick(); look("addi_next_fetch", P_FETCH, 3'd0);

    // LW x2, 8(x1) with three wait states
    ir_i = I_LW;
    tick(); look("lw_dec", P_DECODE, 3'd0);
    chk("lw_dec.imm", imm_o, 32'd8);
    tick(); look("lw_addr", P_ADDR, 3'd0);
    mem_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      look("lw_memrd_wait", P_MEM_RD, 3'd0);
      tick();
    end
    mem_ready_i = 1'b1;
    look("lw_memrd_done", P_MEM_RD, 3'd0);
    tick(); look("lw_wb", P_WB_LD, 3'd0);
    chk("lw_wb.rfa", 32'(rf_addr_a_o), 32'd2);
    tick(); look("lw_next_fetch", P_FETCH, 3'd0);

    // BEQ taken, offset -8
    ir_i = I_BEQ; alu_flag_i = 3'b001;
    tick(); look("beq_dec", P_DECODE, 3'd0);
    chk("beq_dec.imm", imm_o, 32'hFFFF_FFF4);
    tick(); look("beq_cmp", P_BCMP, 3'd1);
    tick(); look("beq_tgt", P_BTGT, 3'd0);
    chk("beq_tgt.imm", imm_o, 32'hFFFF_FFF4);
    tick(); look("beq_next_fetch", P_FETCH, 3'd0);

    // BNE not taken
    ir_i = I_BNE;
    tick(); tick(); look("bne_cmp", P_BCMP, 3'd1);
    tick(); look("bne_fetch", P_FETCH, 3'd0);

    // ADD x0, x1, x2: write suppressed
    ir_i = I_ADDX0; alu_flag_i = 3'b000;
    tick(); tick(); look("addx0_exec", P_EXEC_R, 3'd0);
    tick(); look("addx0_wb", P_WB_X0, 3'd0);
    chk("addx0_wb.rfa", 32'(rf_addr_a_o), 32'd0);
    tick();

    // SUB x3, x1, x2
    ir_i = I_SUB;
    tick(); tick(); look("sub_exec", P_EXEC_R, 3'd1);
    tick(); look("sub_wb", P_WB_R, 3'd1);
    chk("sub_wb.rfa", 32'(rf_addr_a_o), 32'd3);
    tick();

    // JAL x1, +16
    ir_i = I_JAL;
    tick(); look("jal_dec", P_DECODE, 3'd0);
    chk("jal_dec.imm", imm_o, 32'd12);
    tick(); look("jal_link", P_JLINK, 3'd0);
    chk("jal_link.rf", 32'({rf_addr_a_o, rf_addr_b_o}), 32'({5'd1, 5'd0}));
    tick(); look("jal_tgt", P_BTGT, 3'd0);
    tick(); look("jal_next_fetch", P_FETCH, 3'd0);

    // Fetch timeout after 16 cycles without ready
    mem_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      look("tmo_wait", P_FETCH_W, 3'd0);
      tick();
    end
    look("tmo_fault", P_IDLE, 3'd0);
    chk("tmo_fault.flags", 32'({halt_o, fault_o}), 32'h1);
    mem_ready_i = 1'b1;
    tick(); tick();
    look("tmo_sticky", P_IDLE, 3'd0);
    chk("tmo_sticky.flags", 32'({halt_o, fault_o}), 32'h1);

    rst_i = 1'b1;
    look("rst_pulse", P_RESET, 3'd0);
    chk("rst_pulse.flags", 32'({halt_o, fault_o}), 32'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // Illegal opcode
    ir_i = I_ILL;
    look("ill_fetch", P_FETCH, 3'd0);
    tick(); tick();
    look("ill_fault", P_IDLE, 3'd0);
    chk("ill_fault.flags", 32'({halt_o, fault_o}), 32'h1);

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    // HALT
    ir_i = I_HALT;
    tick(); tick();
    look("halt", P_IDLE, 3'd0);
    chk("halt.flags", 32'({halt_o, fault_o}), 32'h2);
    repeat (5) tick();
    look("halt_sticky", P_IDLE, 3'd0);
    chk("halt_sticky.flags", 32'({halt_o, fault_o}), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
